// File: rtl/accelerator_pkg.sv
// Shared types for the accelerator data-side blocks.
//   obi_resp_t  : one OBI response beat {valid, rdata, err}, carried through the
//                 responder's fixed-latency delay line.
//   ObiRespIdle : the "no response" beat, used for bubbles and reset.
package accelerator_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  localparam obi_resp_t ObiRespIdle = '{valid: 1'b0, rdata: 32'h0, err: 1'b0};

endpackage : accelerator_pkg

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response delay line: LATENCY-deep shift register of obi_resp_t.
// A beat presented on resp_i at a clock edge appears on resp_o LATENCY cycles later.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high clear; every stage returns to an idle beat
//   resp_i  : beat entering stage 1 (idle beat when nothing was granted)
//   resp_o  : beat leaving stage LATENCY
module obi_resp_pipe
  import accelerator_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  obi_resp_t resp_i,
  output obi_resp_t resp_o
);

  obi_resp_t stage_q [LATENCY];
  obi_resp_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = resp_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= ObiRespIdle;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule : obi_resp_pipe

// File: rtl/obi_data_mem_responder.sv
// OBI data-memory responder: memory-side end of the core / vector LSU data port.
// Grants requests combinationally, applies byte-enabled writes to a local word array
// and returns one in-order response per grant after a fixed LATENCY.
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   data_req_i          : request valid
//   data_gnt_o          : request accepted this cycle (combinational)
//   data_we_i           : 1 = write, 0 = read
//   data_be_i           : write byte enables
//   data_addr_i         : byte address, bits [1:0] ignored
//   data_wdata_i        : write data
//   data_rvalid_o       : one-cycle response pulse per granted transaction
//   data_rdata_o        : read data (0 for writes and errors)
//   data_err_o          : out-of-range access, qualified by data_rvalid_o
module obi_data_mem_responder
  import accelerator_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 256,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STALL_PERIOD    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IdxW   = $clog2(DEPTH_WORDS);
  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned StallW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  // Address decode
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic            unused_addr;

  assign idx         = data_addr_i[IdxW+1:2];
  assign in_range    = (data_addr_i[31:IdxW+2] == '0);
  assign unused_addr = ^data_addr_i[1:0];

  // Deterministic grant throttling
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic              stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall       = 1'b0;
    if (STALL_PERIOD > 1) begin
      stall       = (stall_cnt_q == StallW'(STALL_PERIOD - 1));
      stall_cnt_d = stall ? '0 : stall_cnt_q + StallW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Grant and outstanding tracking; a response retiring this cycle frees its slot now.
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [OutW-1:0] occupancy;

  assign occupancy  = outstanding_q - OutW'(data_rvalid_o);
  assign data_gnt_o = data_req_i && !reset && !stall && (occupancy < OutW'(MAX_OUTSTANDING));

  always_comb begin
    outstanding_d = outstanding_q;
    if (data_gnt_o && !data_rvalid_o) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!data_gnt_o && data_rvalid_o) begin
      outstanding_d = outstanding_q - OutW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // Word array with per-byte write enable; contents survive reset.
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        mem_we;

  assign mem_we = data_gnt_o && data_we_i && in_range;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response beat captured at the grant edge; the read sees all earlier writes.
  obi_resp_t resp_in, resp_out;

  always_comb begin
    resp_in = ObiRespIdle;
    if (data_gnt_o) begin
      resp_in.valid = 1'b1;
      if (!in_range) begin
        resp_in.err = 1'b1;
      end else if (!data_we_i) begin
        resp_in.rdata = mem_q[idx];
      end
    end
  end

  obi_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .reset  (reset),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign data_rvalid_o = resp_out.valid;
  assign data_rdata_o  = resp_out.rdata;
  assign data_err_o    = resp_out.err;

endmodule : obi_data_mem_responder

// File: tb/tb_obi_data_mem_responder.sv
// Self-checking bench for obi_data_mem_responder. A transaction-level model (word
// array, queue of pending responses with due cycles, stall phase count) predicts
// grant, rvalid, rdata and err every cycle for directed and random traffic.
module tb_obi_data_mem_responder;

  localparam int unsigned DepthWords     = 256;
  localparam int unsigned Latency        = 3;
  localparam int unsigned MaxOutstanding = 2;
  localparam int unsigned StallPeriod    = 4;
  localparam int unsigned IdxW           = $clog2(DepthWords);
  localparam int unsigned Window         = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  obi_data_mem_responder #(
    .DEPTH_WORDS     (DepthWords),
    .LATENCY         (Latency),
    .MAX_OUTSTANDING (MaxOutstanding),
    .STALL_PERIOD    (StallPeriod)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_addr_i   (addr),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (err)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
    logic        err;
  } exp_resp_t;

  logic [31:0]  mem_m [DepthWords];
  exp_resp_t    pend_q [$];
  int unsigned  now = 0;
  int unsigned  phase = 0;
  logic         rst_prev = 1'b0;
  logic         gnt_seen = 1'b0;
  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: predict and compare at the falling edge, advance the model at
  // the rising edge, then leave 1 time unit for the caller to change inputs.
  task automatic step();
    logic        stall, exp_rv, exp_gnt;
    int unsigned busy;
    exp_resp_t   r;
    logic [31:0] mask;
    @(negedge clk);
    stall  = (StallPeriod > 1) && (phase == StallPeriod - 1);
    exp_rv = 1'b0;
    if (pend_q.size() != 0) exp_rv = (pend_q[0].due == now);
    busy    = pend_q.size() - (exp_rv ? 1 : 0);
    exp_gnt = !reset && req && !stall && (busy < MaxOutstanding);
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    // Registered outputs only clear at the first reset edge.
    if (!(reset && !rst_prev)) begin
      check_eq("rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv) begin
        check_eq("rdata", rdata, pend_q[0].rdata);
        check_eq("err", 32'(err), 32'(pend_q[0].err));
      end
    end
    @(posedge clk);
    if (reset) begin
      pend_q.delete();
      phase = 0;
    end else begin
      if (exp_rv) void'(pend_q.pop_front());
      if (exp_gnt) begin
        r.due   = now + Latency;
        r.err   = (addr >= 4 * DepthWords);
        r.rdata = (r.err || we) ? 32'h0 : mem_m[addr[IdxW+1:2]];
        pend_q.push_back(r);
        if (we && !r.err) begin
          mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
          mem_m[addr[IdxW+1:2]] = (mem_m[addr[IdxW+1:2]] & ~mask) | (wdata & mask);
        end
      end
      phase = (StallPeriod > 1) ? (phase + 1) % StallPeriod : 0;
    end
    now++;
    rst_prev = reset;
    gnt_seen = exp_gnt;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    req = 1'b0;
    for (int i = 0; i < int'(n); i++) step();
  endtask

  // Hold one request until it is granted (bounded).
  task automatic xfer(input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    gnt_seen = 1'b0;
    for (int i = 0; i < 20 && !gnt_seen; i++) step();
    if (!gnt_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL xfer_timeout: addr %h never granted, want grant within 20 cycles", a);
    end
    req = 1'b0;
  endtask

  initial begin
    // Reset with a pending request: grant must stay low.
    reset = 1'b1;
    req   = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    req   = 1'b0;
    step();

    // Preload the test window so every in-range read has a known value.
    for (int i = 0; i < int'(Window); i++) xfer(1'b1, 4'hF, 32'(i * 4), $urandom);

    // Full write then read back.
    xfer(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    xfer(1'b0, 4'h0, 32'h10, 32'h0);
    idle(5);

    // Partial write merges lanes 0 and 2 only.
    xfer(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    xfer(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    xfer(1'b0, 4'h0, 32'h20, 32'h0);
    idle(5);

    // Request held high: outstanding limit and stall shape the grant pattern.
    req = 1'b1; we = 1'b0; addr = 32'h10;
    for (int i = 0; i < 14; i++) step();
    idle(6);

    // Out-of-range accesses error out and leave the array untouched.
    xfer(1'b0, 4'h0, 32'h400, 32'h0);
    xfer(1'b1, 4'hF, 32'h400, 32'hFFFF_FFFF);
    xfer(1'b0, 4'h0, 32'h0, 32'h0);
    xfer(1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0);
    xfer(1'b0, 4'h0, 32'h3FC, 32'h0);
    idle(6);

    // Reset with two reads in flight: no stale responses, earlier write kept.
    xfer(1'b1, 4'hF, 32'h14, 32'hCAFE_F00D);
    idle(5);
    xfer(1'b0, 4'h0, 32'h14, 32'h0);
    xfer(1'b0, 4'h0, 32'h18, 32'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle(6);
    xfer(1'b0, 4'h0, 32'h14, 32'h0);
    idle(5);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1);
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        addr = 32'h400 + $urandom_range(0, 4095);
      end else begin
        addr = 32'($urandom_range(0, Window - 1) * 4 + $urandom_range(0, 3));
      end
      step();
    end
    reset = 1'b0;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_obi_data_mem_responder
